// File: rtl/vmem_pkg.sv
// Shared defaults, op encodings and FSM state type for the vector memory unit.
package vmem_pkg;

    localparam int LANES_DEF  = 16;
    localparam int WIDTH_DEF  = 16;
    localparam int ADDR_W_DEF = 16;

    localparam logic OP_VLD = 1'b0;
    localparam logic OP_VST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LDRAIN,
        STORE,
        DONE
    } state_t;

endpackage

// File: rtl/vmem_addr_gen.sv
// Lane counter and address accumulator: load latches base/stride, step advances
// one lane and stops at the last lane so the final address stays visible.
module vmem_addr_gen #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     step,
    input  logic [ADDR_W-1:0]        base,
    input  logic [7:0]               stride,
    output logic [ADDR_W-1:0]        addr,
    output logic [$clog2(LANES)-1:0] lane,
    output logic                     last
);

    localparam int LANE_W = $clog2(LANES);

    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] stride_q;
    logic [LANE_W-1:0] cnt;

    assign last = (cnt == LANE_W'(LANES - 1));
    assign addr = acc;
    assign lane = cnt;

    // Accumulator wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            stride_q <= '0;
            cnt      <= '0;
        end else if (load) begin
            acc      <= base;
            stride_q <= ADDR_W'(stride);
            cnt      <= '0;
        end else if (step && !last) begin
            acc <= acc + stride_q;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vector_mem_unit.sv
// Vector load/store sequencer: moves LANES elements between a word memory and a
// packed vector register. Define VMEM_STRIDE_EN to add a per-request stride port.
module vector_mem_unit
    import vmem_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op,
    input  logic [ADDR_W-1:0]      base_addr,
`ifdef VMEM_STRIDE_EN
    input  logic [7:0]             stride,
`endif
    input  logic [LANES*WIDTH-1:0] vec_in,
    output logic [LANES*WIDTH-1:0] vec_out,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [WIDTH-1:0]       mem_wdata,
    input  logic [WIDTH-1:0]       mem_rdata
);

    localparam int LANE_W = $clog2(LANES);

    state_t state, state_nx;

    logic              ag_load, ag_step, ag_last;
    logic [LANE_W-1:0] lane;
    logic [7:0]        stride_in;
    logic [WIDTH-1:0]  snap [LANES];
    logic [WIDTH-1:0]  vout [LANES];
    logic [WIDTH-1:0]  wdata_hold;
    logic              cap_en;
    logic [LANE_W-1:0] cap_idx;

`ifdef VMEM_STRIDE_EN
    assign stride_in = stride;
`else
    assign stride_in = 8'd1;
`endif

    vmem_addr_gen #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (ag_load),
        .step   (ag_step),
        .base   (base_addr),
        .stride (stride_in),
        .addr   (mem_addr),
        .lane   (lane),
        .last   (ag_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ag_load  = 1'b0;
        ag_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ag_load  = 1'b1;
                    state_nx = (op == OP_VST) ? STORE : LOAD;
                end
            end
            LOAD: begin
                ag_step = 1'b1;
                if (ag_last) state_nx = LDRAIN;
            end
            LDRAIN: state_nx = DONE;
            STORE: begin
                ag_step = 1'b1;
                if (ag_last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read data arrives one cycle after its request, so the capture lane trails by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_en     <= 1'b0;
            cap_idx    <= '0;
            wdata_hold <= '0;
            for (int k = 0; k < LANES; k++) begin
                vout[k] <= '0;
                snap[k] <= '0;
            end
        end else begin
            if (ag_load) begin
                for (int k = 0; k < LANES; k++) snap[k] <= vec_in[k*WIDTH +: WIDTH];
            end
            cap_en  <= (state == LOAD);
            cap_idx <= lane;
            if (cap_en) vout[cap_idx] <= mem_rdata;
            if (state == STORE) wdata_hold <= snap[lane];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign vec_out[g*WIDTH +: WIDTH] = vout[g];
    end

    assign mem_re    = (state == LOAD);
    assign mem_we    = (state == STORE);
    assign mem_wdata = mem_we ? snap[lane] : wdata_hold;
    assign busy      = (state == LOAD) || (state == LDRAIN) || (state == STORE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_vector_mem_unit.sv
// Scoreboard bench for vector_mem_unit: driver queues expected accesses and
// completions from a reference model, a negedge monitor pops and compares.
module tb_vector_mem_unit;

    localparam int LANES  = 16;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 16;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   op;
    logic [ADDR_W-1:0]      base_addr;
    logic [7:0]             stride;
    logic [LANES*WIDTH-1:0] vec_in;
    logic [LANES*WIDTH-1:0] vec_out;
    logic                   busy;
    logic                   done;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_re;
    logic                   mem_we;
    logic [WIDTH-1:0]       mem_wdata;
    logic [WIDTH-1:0]       mem_rdata;

    vector_mem_unit #(
        .LANES  (LANES),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .base_addr (base_addr),
`ifdef VMEM_STRIDE_EN
        .stride    (stride),
`endif
        .vec_in    (vec_in),
        .vec_out   (vec_out),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem     [65536];
    logic [15:0] ref_mem [65536];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        int           cyc;
        logic [255:0] vec;
    } done_t;

    acc_t  acc_q[$];
    done_t done_q[$];

    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [255:0] last_vec;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        acc_t  a;
        done_t d;
        if (!rst) begin
            if (mem_re || mem_we) begin
                chk("re_we_exclusive", 256'(mem_re & mem_we), 256'd0);
                if (acc_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_access: re=%0b we=%0b addr=%h, none expected", mem_re, mem_we, mem_addr);
                end else begin
                    a = acc_q.pop_front();
                    chk("access_is_write", 256'(mem_we), 256'(a.we));
                    chk("access_addr", 256'(mem_addr), 256'(a.addr));
                    if (a.we) chk("store_data", 256'(mem_wdata), 256'(a.data));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, none expected", cyc);
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle", 256'(cyc), 256'(d.cyc));
                    chk("vec_out", vec_out, d.vec);
                    chk("busy_at_done", 256'(busy), 256'd0);
                    chk("accesses_complete", 256'(acc_q.size()), 256'd0);
                end
            end
        end
    end

    // disturb: 0 none, 1 start pulse in cycle 5, 2 vec_in change in cycle 5, 3 reset in cycle 8
    task automatic run_op(input logic o, input logic [15:0] base, input logic [7:0] str, input int disturb);
        logic [255:0] exp_vec;
        logic [15:0]  a;
        int           issue;
        bit           got_done;
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        base_addr = base;
        stride    = str;
        exp_vec   = last_vec;
        for (int k = 0; k < LANES; k++) begin
            a = base + 16'(k) * 16'(str);
            if (o) begin
                acc_q.push_back('{1'b1, a, vec_in[k*16 +: 16]});
                ref_mem[a] = vec_in[k*16 +: 16];
            end else begin
                acc_q.push_back('{1'b0, a, 16'h0});
                exp_vec[k*16 +: 16] = ref_mem[a];
            end
        end
        if (!o) last_vec = exp_vec;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        base_addr = 16'($urandom);
        stride    = 8'($urandom);
        issue     = cyc;
        chk("busy_after_accept", 256'(busy), 256'd1);
        done_q.push_back('{issue + (o ? 16 : 17), exp_vec});
        got_done = 1'b0;
        for (int n = 2; n <= 40 && !got_done; n++) begin
            @(negedge clk);
            if (disturb == 1 && n == 5) begin
                start = 1'b1;
                op    = ~o;
            end
            if (disturb == 1 && n == 6) start = 1'b0;
            if (disturb == 2 && n == 5) begin
                for (int k = 0; k < LANES; k++) vec_in[k*16 +: 16] = 16'($urandom);
            end
            if (disturb == 3 && n == 8) begin
                #1 rst = 1'b1;
                @(negedge clk);
                chk("rst_busy", 256'(busy), 256'd0);
                chk("rst_mem_re", 256'(mem_re), 256'd0);
                chk("rst_done", 256'(done), 256'd0);
                chk("rst_vec_out", vec_out, 256'd0);
                rst = 1'b0;
                acc_q.delete();
                done_q.delete();
                last_vec = '0;
                return;
            end
            if (done) got_done = 1'b1;
        end
        if (!got_done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done within 40 cycles, op=%0b base=%h", o, base);
        end
    endtask

    task automatic rand_vec();
        for (int k = 0; k < LANES; k++) vec_in[k*16 +: 16] = 16'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp_c;
        logic [255:0] got_c;
        logic [15:0]  v;
        rst       = 1'b1;
        start     = 1'b0;
        op        = 1'b0;
        base_addr = '0;
        stride    = 8'd1;
        vec_in    = '0;
        mem_rdata = '0;
        last_vec  = '0;
        for (int i = 0; i < 65536; i++) begin
            v          = 16'($urandom);
            mem[i]     = v;
            ref_mem[i] = v;
        end
        for (int k = 0; k < LANES; k++) begin
            mem[16 + k]     = 16'h3C00 + 16'(k);
            ref_mem[16 + k] = 16'h3C00 + 16'(k);
        end
        repeat (3) @(negedge clk);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_done", 256'(done), 256'd0);
        chk("reset_strobes", 256'({mem_re, mem_we}), 256'd0);
        chk("reset_mem_addr", 256'(mem_addr), 256'd0);
        chk("reset_mem_wdata", 256'(mem_wdata), 256'd0);
        chk("reset_vec_out", vec_out, 256'd0);
        rst = 1'b0;

        run_op(1'b0, 16'h0010, 8'd1, 0);
        for (int k = 0; k < LANES; k++) exp_c[k*16 +: 16] = 16'h3C00 + 16'(k);
        chk("vld_directed_lanes", vec_out, exp_c);

        for (int k = 0; k < LANES; k++) vec_in[k*16 +: 16] = 16'h4000 | 16'(k);
        run_op(1'b1, 16'h0100, 8'd1, 0);
        @(negedge clk);
        for (int k = 0; k < LANES; k++) begin
            exp_c[k*16 +: 16] = 16'h4000 | 16'(k);
            got_c[k*16 +: 16] = mem[16'h0100 + 16'(k)];
        end
        chk("vst_directed_memory", got_c, exp_c);
        chk("vst_keeps_vec_out", vec_out, last_vec);

        rand_vec();
        run_op(1'b1, 16'hFFF8, 8'd1, 0);
        run_op(1'b0, 16'hFFFE, 8'd1, 0);

        run_op(1'b0, 16'h0010, 8'd1, 1);
        rand_vec();
        run_op(1'b1, 16'h0200, 8'd1, 2);
        run_op(1'b0, 16'h0200, 8'd1, 0);

        run_op(1'b0, 16'($urandom), 8'd1, 3);
        run_op(1'b0, 16'h0010, 8'd1, 0);

        for (int i = 0; i < 8; i++) begin
            rand_vec();
            run_op(1'($urandom), 16'($urandom), 8'd1, 0);
        end

`ifdef VMEM_STRIDE_EN
        run_op(1'b0, 16'h0000, 8'd4, 0);
        run_op(1'b0, 16'h0030, 8'd0, 0);
        rand_vec();
        run_op(1'b1, 16'($urandom), 8'd0, 0);
        for (int i = 0; i < 4; i++) begin
            rand_vec();
            run_op(1'($urandom), 16'($urandom), 8'($urandom), 0);
        end
`endif

        repeat (3) @(negedge clk);
        chk("queues_drained", 256'(acc_q.size() + done_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
